pipelined_cla_adder: RTL
========================

PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

Interface
REQ-001 W, default 16: operand width in bits; legal values are 2..64.
REQ-002 S, default 2: pipeline stage count; W SHALL be divisible by S; slice width is G = W/S.
REQ-003 i_clk  in  1  single clock; all state updates on its rising edge.
REQ-004 i_rst  in  1  reset, synchronous and active-high.
REQ-005 i_valid  in  1  operand set present on i_add1/i_add2/i_cin/i_mode.
REQ-006 o_ready  out  1  block can accept an operand set this cycle.
REQ-007 i_add1  in  W  first operand.
REQ-008 i_add2  in  W  second operand.
REQ-009 i_cin  in  1  carry-in; ignored in subtract modes.
REQ-010 i_mode  in  2  00 unsigned add, 01 signed add, 10 unsigned subtract, 11 signed subtract.
REQ-011 o_valid  out  1  o_result/o_ovf hold a completed result.
REQ-012 i_ready  in  1  downstream accepts the result this cycle.
REQ-013 o_result  out  W+1  result; bit W is defined in REQ-020.
REQ-014 o_ovf  out  1  overflow flag, defined in REQ-021.

Function
- Transfers:
  REQ-015 An input transfer SHALL occur when i_valid && o_ready; an output transfer SHALL occur when o_valid && i_ready.
  REQ-016 Define adv = !o_valid || i_ready. All pipeline registers SHALL update only when adv=1, and o_ready SHALL equal adv.
- Operation:
  REQ-017 Subtract modes SHALL compute i_add1 + ~i_add2 + 1; add modes SHALL compute i_add1 + i_add2 + i_cin.
  REQ-018 Stage k (0..S-1) SHALL add bits [k*G +: G] with a G-bit lookahead slice; its carry-in is the registered carry-out of stage k-1, and stage 0 uses the mode carry-in.
  REQ-019 Upper operand slices SHALL be delayed (skewed) and completed lower sum slices SHALL be delayed (deskewed) so that all W sum bits of one transfer emerge together.
- Result bit W and overflow:
  REQ-020 o_result[W] SHALL be: unsigned add = carry-out; unsigned subtract = borrow (inverted carry-out); signed modes = sign bit of the exact (W+1)-bit two's-complement result, i.e. sum[W-1] XOR overflow.
  REQ-021 o_ovf SHALL be: signed modes = carry into bit W-1 XOR carry out of bit W-1; unsigned add = carry-out; unsigned subtract = borrow.
- Timing and order:
  REQ-022 Latency SHALL be exactly S cycles: a result is presented on o_valid S rising edges after its input transfer when adv stays 1.
  REQ-023 With i_ready=1 throughout, throughput SHALL be one result per cycle, with no bubbles inserted.
  REQ-024 While o_valid=1 and i_ready=0, o_result, o_ovf, o_valid and all internal stages SHALL hold; no data SHALL be lost or duplicated.
  REQ-025 Each stage SHALL carry its own valid bit; bubbles (i_valid=0) SHALL propagate as invalid entries and SHALL NOT produce o_valid.
  REQ-026 Results SHALL leave in the same order as the inputs were accepted; mode and carry-in SHALL travel with their own operands.

Reset
REQ-027 While i_rst=1 at a rising edge, all stage valid bits SHALL clear; afterwards o_valid=0, o_result=0 and o_ovf=0.
REQ-028 Reset SHALL take priority over adv, and in-flight operands SHALL be discarded.
REQ-029 o_ready SHALL be 1 in the first cycle after reset.

Structure
REQ-030 The mode encodings (ADD_U, ADD_S, SUB_U, SUB_S) SHALL be defined in the shared package cla_pkg.
REQ-031 The generate/propagate slice SHALL be a sub-module cla_slice, parameter G, with inputs a, b, cin and outputs sum, cout, c_msb; c_msb is the carry into the slice MSB.
REQ-032 S=1 SHALL be legal and SHALL degenerate to a single registered W-bit adder.

Verification
All scenarios use W=8, S=2.
REQ-033 Unsigned add: 200 + 100, cin=0 -> after 2 cycles o_result=9'h12C, o_ovf=1.
REQ-034 Signed add: 0x9C + 0x9C (-100 + -100) -> o_result=9'h138 (-200), o_ovf=1; then 0x10 + 0x20 -> 9'h030, o_ovf=0.
REQ-035 Unsigned subtract: 5 - 7 -> o_result=9'h1FE, o_ovf=1; add with cin=1: 0xFF + 0x00 -> 9'h100.
REQ-036 Back-pressure: stream 4 back-to-back inputs, drop i_ready for 3 cycles once o_valid=1 -> o_result stable, o_ready=0, and all 4 results delivered in order.
REQ-037 Reset mid-flight: assert i_rst with 2 entries in flight -> o_valid=0 next cycle, no stale result later, o_ready=1.
REQ-038 Random: 10k operand sets over all modes with random i_valid/i_ready -> every result matches the reference model, in order.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder: operation modes
// and mode decode helpers.
package cla_pkg;

    localparam int unsigned MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        ADD_U = 2'b00,
        ADD_S = 2'b01,
        SUB_U = 2'b10,
        SUB_S = 2'b11
    } mode_e;

    function automatic logic is_sub(mode_e m);
        return (m == SUB_U) || (m == SUB_S);
    endfunction

endpackage

// File: rtl/pipelined_cla_adder_if.sv
// Valid/ready operand and result bundle for pipelined_cla_adder.
interface pipelined_cla_adder_if #(
    parameter int unsigned W = 16
);
    import cla_pkg::*;

    logic         i_valid;
    logic         o_ready;
    logic [W-1:0] i_add1;
    logic [W-1:0] i_add2;
    logic         i_cin;
    mode_e        i_mode;
    logic         o_valid;
    logic         i_ready;
    logic [W:0]   o_result;
    logic         o_ovf;

    modport slave (
        input  i_valid, i_add1, i_add2, i_cin, i_mode, i_ready,
        output o_ready, o_valid, o_result, o_ovf
    );

    modport master (
        output i_valid, i_add1, i_add2, i_cin, i_mode, i_ready,
        input  o_ready, o_valid, o_result, o_ovf
    );

endinterface

// File: rtl/cla_slice.sv
// G-bit carry-lookahead slice; c_msb is the carry into the slice MSB so the
// top slice can form the signed overflow flag.
module cla_slice #(
    parameter int unsigned G = 8
) (
    input  logic [G-1:0] a,
    input  logic [G-1:0] b,
    input  logic         cin,
    output logic [G-1:0] sum,
    output logic         cout,
    output logic         c_msb
);

    logic [G-1:0] g;
    logic [G-1:0] p;
    logic [G:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    // Each carry is a flat sum-of-products over generate/propagate terms.
    always_comb begin
        logic acc;
        logic pp;
        acc  = 1'b0;
        pp   = 1'b0;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < int'(G); i++) begin
            acc = g[i];
            pp  = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc = acc | (pp & g[j]);
                pp  = pp & p[j];
            end
            c[i+1] = acc | (pp & cin);
        end
    end

    assign sum   = p ^ c[G-1:0];
    assign cout  = c[G];
    assign c_msb = c[G-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// S-stage pipelined carry-lookahead adder/subtractor with valid/ready flow
// control; one G-bit slice per stage with operand skew and sum deskew.
module pipelined_cla_adder
    import cla_pkg::*;
#(
    parameter int unsigned W = 16,
    parameter int unsigned S = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    pipelined_cla_adder_if.slave  bus
);

    localparam int unsigned G = W / S;

    logic adv;

    // Per-stage slice inputs: stage 0 from the bus, stage k from register k-1.
    logic [W-1:0] a_s   [S];
    logic [W-1:0] b_s   [S];
    logic [W-1:0] p_s   [S];
    logic         c_s   [S];
    mode_e        m_s   [S];
    logic         v_s   [S];

    logic [G-1:0] ss    [S];
    logic         co    [S];
    logic         cm    [S];

    // Inter-stage registers; only entries 0..S-2 carry data.
    logic [W-1:0] a_q   [S];
    logic [W-1:0] b_q   [S];
    logic [W-1:0] sum_q [S];
    logic         c_q   [S];
    mode_e        m_q   [S];
    logic         v_q   [S];

    logic         out_v_q;
    logic [W:0]   res_q;
    logic [W:0]   res_d;
    logic         ovf_q;
    logic         ovf_d;

    assign adv = !out_v_q || bus.i_ready;

    always_comb begin
        a_s[0] = bus.i_add1;
        b_s[0] = is_sub(bus.i_mode) ? ~bus.i_add2 : bus.i_add2;
        c_s[0] = is_sub(bus.i_mode) ? 1'b1 : bus.i_cin;
        m_s[0] = bus.i_mode;
        v_s[0] = bus.i_valid;
        p_s[0] = '0;
        for (int unsigned k = 1; k < S; k++) begin
            a_s[k] = a_q[k-1];
            b_s[k] = b_q[k-1];
            c_s[k] = c_q[k-1];
            m_s[k] = m_q[k-1];
            v_s[k] = v_q[k-1];
            p_s[k] = sum_q[k-1];
        end
    end

    for (genvar k = 0; k < int'(S); k++) begin : g_slice
        cla_slice #(.G(G)) u_slice (
            .a     (a_s[k][k*G +: G]),
            .b     (b_s[k][k*G +: G]),
            .cin   (c_s[k]),
            .sum   (ss[k]),
            .cout  (co[k]),
            .c_msb (cm[k])
        );
    end

    // Result bit W and overflow from the top slice.
    always_comb begin
        logic [W-1:0] full;
        logic         ovf_sgn;
        full    = p_s[S-1] | (W'(ss[S-1]) << ((S - 1) * G));
        ovf_sgn = cm[S-1] ^ co[S-1];
        res_d   = {1'b0, full};
        ovf_d   = 1'b0;
        case (m_s[S-1])
            ADD_U: begin
                res_d = {co[S-1], full};
                ovf_d = co[S-1];
            end
            SUB_U: begin
                res_d = {~co[S-1], full};
                ovf_d = ~co[S-1];
            end
            default: begin
                res_d = {full[W-1] ^ ovf_sgn, full};
                ovf_d = ovf_sgn;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int unsigned k = 0; k < S; k++) begin
                v_q[k]   <= 1'b0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                sum_q[k] <= '0;
                c_q[k]   <= 1'b0;
                m_q[k]   <= ADD_U;
            end
            out_v_q <= 1'b0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
        end else if (adv) begin
            for (int unsigned k = 0; k + 1 < S; k++) begin
                v_q[k]   <= v_s[k];
                a_q[k]   <= a_s[k];
                b_q[k]   <= b_s[k];
                c_q[k]   <= co[k];
                m_q[k]   <= m_s[k];
                sum_q[k] <= p_s[k] | (W'(ss[k]) << (k * G));
            end
            out_v_q <= v_s[S-1];
            if (v_s[S-1]) begin
                res_q <= res_d;
                ovf_q <= ovf_d;
            end
        end
    end

    assign bus.o_ready  = adv;
    assign bus.o_valid  = out_v_q;
    assign bus.o_result = res_q;
    assign bus.o_ovf    = ovf_q;

endmodule
